// File: rtl/sys_operand_skew.sv
// sys_operand_skew: operand FIFO and diagonal lane skew feeding a 4x4 systolic array
// Optional bubble counter enabled by SKEW_BUBBLE_CNT_EN.
module sys_operand_skew #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_aresetn,
   input  logic                          clear,
   input  logic                          start,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [31:0]                   in_a,
   input  logic [31:0]                   in_b,
   output logic [7:0]                    out_a1,
   output logic [7:0]                    out_a2,
   output logic [7:0]                    out_a3,
   output logic [7:0]                    out_a4,
   output logic [7:0]                    out_b1,
   output logic [7:0]                    out_b2,
   output logic [7:0]                    out_b3,
   output logic [7:0]                    out_b4,
   output logic                          busy,
   output logic                          drained,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic [15:0]                   bubble_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t        state;
   logic [63:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          fl_latch;
   logic [1:0]    dcnt;
   logic          push, pop, go_drain;
   logic [63:0]   stage0;
   logic [7:0]    sa [4], sb [4];
   assign in_ready = (level < (AW+1)'(FIFO_DEPTH)) && state != DRAIN;
   assign push     = in_valid && in_ready;
   assign pop      = state == RUN && level != '0;
   assign go_drain = state == RUN && fl_latch && level == '0 && !push;
   assign stage0   = pop ? mem[rd_ptr] : '0;
   assign busy     = state != IDLE;
   always_ff @(posedge s_axi_aclk)
      if (push) mem[wr_ptr] <= {in_b, in_a};
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         fl_latch <= 1'b0;
         dcnt     <= '0;
         drained  <= 1'b0;
      end else if (clear) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         fl_latch <= 1'b0;
         dcnt     <= '0;
         drained  <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr + AW'(push);
         rd_ptr  <= rd_ptr + AW'(pop);
         level   <= level + (AW+1)'(push) - (AW+1)'(pop);
         drained <= state == DRAIN && dcnt == 2'd3;
         case (state)
            IDLE: if (start) begin
               state    <= RUN;
               fl_latch <= flush;
            end
            RUN: begin
               if (flush) fl_latch <= 1'b1;
               if (go_drain) begin
                  state    <= DRAIN;
                  dcnt     <= '0;
                  fl_latch <= 1'b0;
               end
            end
            DRAIN: begin
               dcnt <= dcnt + 2'd1;
               if (dcnt == 2'd3) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   // lane k is a shift chain of k+1 registers, producing the diagonal wavefront
   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [7:0] a_q [k+1];
      logic [7:0] b_q [k+1];
      always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
         if (!s_axi_aresetn) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
         end else if (clear) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
         end else begin
            a_q[0] <= stage0[8*k +: 8];
            b_q[0] <= stage0[32+8*k +: 8];
            for (int j = 1; j <= k; j++) begin
               a_q[j] <= a_q[j-1];
               b_q[j] <= b_q[j-1];
            end
         end
      assign sa[k] = a_q[k];
      assign sb[k] = b_q[k];
   end
   assign out_a1 = sa[0];
   assign out_a2 = sa[1];
   assign out_a3 = sa[2];
   assign out_a4 = sa[3];
   assign out_b1 = sb[0];
   assign out_b2 = sb[1];
   assign out_b3 = sb[2];
   assign out_b4 = sb[3];
`ifdef SKEW_BUBBLE_CNT_EN
   logic bubble;
   // the cycle that enters DRAIN is the end of the stream, not an underflow
   assign bubble = state == RUN && level == '0 && !go_drain;
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) bubble_cnt <= '0;
      else if (clear || (state == IDLE && start)) bubble_cnt <= '0;
      else if (bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
`else
   assign bubble_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_sys_operand_skew.sv
// tb_sys_operand_skew: scoreboard bench for sys_operand_skew
module tb_sys_operand_skew;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        clear = 1'b0, start = 1'b0, flush = 1'b0, in_valid = 1'b0;
   logic [31:0] in_a = '0, in_b = '0;
   logic        in_ready, busy, drained;
   logic [7:0]  out_a1, out_a2, out_a3, out_a4, out_b1, out_b2, out_b3, out_b4;
   logic [3:0]  level;
   logic [15:0] bubble_cnt;
   int          total = 0, bad = 0, cyc = 0;
   logic [7:0]  oa [4], ob [4];
   logic [15:0] lq [4][$];
   int          tq [4][$];

   sys_operand_skew #(.FIFO_DEPTH(8)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .clear(clear), .start(start), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3), .out_a4(out_a4),
      .out_b1(out_b1), .out_b2(out_b2), .out_b3(out_b3), .out_b4(out_b4),
      .busy(busy), .drained(drained), .level(level), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign oa[0] = out_a1;
   assign oa[1] = out_a2;
   assign oa[2] = out_a3;
   assign oa[3] = out_a4;
   assign ob[0] = out_b1;
   assign ob[1] = out_b2;
   assign ob[2] = out_b3;
   assign ob[3] = out_b4;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {out_a1, out_a2, out_a3, out_a4, out_b1, out_b2, out_b3, out_b4};
   endfunction

   function automatic logic [31:0] rw();
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'($urandom_range(255, 1));
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input logic [31:0] a, input logic [31:0] b);
      for (int k = 0; k < 4; k++) lq[k].push_back({a[8*k +: 8], b[8*k +: 8]});
   endtask

   task automatic sb_clear();
      for (int k = 0; k < 4; k++) begin
         lq[k].delete();
         tq[k].delete();
      end
   endtask

   function automatic int sb_size();
      int n = 0;
      for (int k = 0; k < 4; k++) n += lq[k].size() + tq[k].size();
      return n;
   endfunction

   task automatic drive_push(input logic [31:0] a, input logic [31:0] b);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      if (in_ready) sb_push(a, b);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drained(output int dr);
      dr = 0;
      for (int i = 0; i < 60; i++) begin
         if (drained) break;
         if (busy && !in_ready) dr++;
         tick();
      end
      check("drained_seen", drained, 1);
      check("busy_at_drained", busy, 0);
      tick();
      check("drained_pulse", drained, 0);
   endtask

   // lanes carry nonzero bytes, so any nonzero output lane is a real word
   always @(negedge clk)
      for (int k = 0; k < 4; k++)
         if ({oa[k], ob[k]} != 16'h0) begin
            if (lq[k].size() == 0) check("sb_extra", {oa[k], ob[k]}, 0);
            else begin
               check("sb_lane", {oa[k], ob[k]}, lq[k].pop_front());
               if (k == 0) for (int j = 1; j < 4; j++) tq[j].push_back(cyc + j);
               else check("sb_time", cyc, tq[k].pop_front());
            end
         end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int dr, hold, exp_bub, nd;
      logic acc;
      logic [31:0] wa, wb;
`ifdef SKEW_BUBBLE_CNT_EN
      exp_bub = 2;
`else
      exp_bub = 0;
`endif
      tick();
      tick();
      check("rst_ready", in_ready, 1);
      check("rst_outs", outs(), 0);
      check("rst_busy", busy, 0);
      check("rst_drained", drained, 0);
      check("rst_level", level, 0);
      check("rst_bubble", bubble_cnt, 0);
      rst_n = 1'b1;
      tick();
      check("idle_level", level, 0);

      // prefill then run
      drive_push(32'h04030201, 32'h08070605);
      tick();
      tick();
      tick();
      check("prefill_level", level, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_busy", busy, 1);
      tick();
      check("pf_a1", {out_a1, out_b1}, 16'h0105);
      tick();
      check("pf_a2", {out_a2, out_b2}, 16'h0206);
      tick();
      check("pf_a3", {out_a3, out_b3}, 16'h0307);
      tick();
      check("pf_a4", {out_a4, out_b4}, 16'h0408);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_drained(dr);
      check("pf_drain_len", dr, 4);
      check("pf_sb_empty", sb_size(), 0);

      // back-to-back fill to full, ninth word held, then drain
      for (int i = 0; i < 8; i++) drive_push(rw(), rw());
      check("full_level", level, 8);
      check("full_ready", in_ready, 0);
      wa = rw();
      wb = rw();
      in_a = wa;
      in_b = wb;
      in_valid = 1'b1;
      start = 1'b1;
      flush = 1'b1;
      hold = 0;
      acc = 1'b0;
      for (int i = 0; i < 10 && !acc; i++) begin
         acc = in_ready;
         if (acc) sb_push(wa, wb);
         else hold++;
         tick();
         start = 1'b0;
         flush = 1'b0;
      end
      in_valid = 1'b0;
      check("full_hold", hold, 2);
      wait_drained(dr);
      check("b2b_drain_len", dr, 4);
      check("b2b_bubble", bubble_cnt, 0);
      check("b2b_sb_empty", sb_size(), 0);

      // stream with a two-cycle underflow gap
      start = 1'b1;
      drive_push(rw(), rw());
      start = 1'b0;
      for (int i = 0; i < 5; i++) drive_push(rw(), rw());
      tick();
      tick();
      for (int i = 0; i < 3; i++) drive_push(rw(), rw());
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_drained(dr);
      check("uf_drain_len", dr, 4);
      check("uf_bubble", bubble_cnt, exp_bub);
      check("uf_sb_empty", sb_size(), 0);

      // clear mid-stream
      for (int i = 0; i < 4; i++) drive_push(rw(), rw());
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("clr_pre_level", level, 3);
      check("clr_pre_nonzero", outs() != 0, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      sb_clear();
      check("clr_level", level, 0);
      check("clr_outs", outs(), 0);
      check("clr_busy", busy, 0);
      check("clr_drained", drained, 0);
      check("clr_ready", in_ready, 1);
      tick();
      check("clr_idle_level", level, 0);

      // asynchronous reset during DRAIN
      drive_push(rw(), rw());
      start = 1'b1;
      flush = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy && !in_ready) break;
         tick();
      end
      check("ar_in_drain", busy && !in_ready, 1);
      #2;
      rst_n = 1'b0;
      #1;
      sb_clear();
      check("ar_outs", outs(), 0);
      check("ar_busy", busy, 0);
      check("ar_level", level, 0);
      check("ar_ready", in_ready, 1);
      check("ar_drained", drained, 0);
      check("ar_bubble", bubble_cnt, 0);
      tick();
      tick();
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         if (drained) nd++;
         tick();
      end
      check("ar_no_drained", nd, 0);
      check("ar_busy_after", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
